sccb_init_seq: RTL and testbench

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq.sv | 175 +++++++++++++++++
 tb/tb_sccb_init_seq.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// SCCB init sequencer: walks a register table and issues camera writes.
// Ports: start/busy/done control, table read port, 1 ms delay tick,
// SCCB controller request (ctrl/sub_adr/data valid-ready) and bus busy.
module sccb_init_seq #(
    parameter int DATA_W    = 8,
    parameter int ENTRY_AMT = 64,
    parameter int DLY_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(ENTRY_AMT):0]   entry_cnt_o,
    output logic [$clog2(ENTRY_AMT)-1:0] tbl_addr_o,
    input  logic [2*DATA_W-1:0]          tbl_data_i,
    input  logic                         dly_tick_i,
    output logic                         trans_type_o,
    output logic [1:0]                   phase_amt_o,
    output logic                         ctrl_vld_o,
    input  logic                         ctrl_rdy_i,
    output logic [DATA_W-1:0]            tx_sub_adr_o,
    output logic                         tx_sub_adr_vld_o,
    input  logic                         tx_sub_adr_rdy_i,
    output logic [DATA_W-1:0]            tx_data_o,
    output logic                         tx_data_vld_o,
    input  logic                         tx_data_rdy_i,
    input  logic                         sccb_busy_i
);

    localparam int AW = $clog2(ENTRY_AMT);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST = AW'(ENTRY_AMT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_BUS,
        S_DELAY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_vld;
    logic               r_wb_first;
    logic [AW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [DLY_W-1:0]   r_dly;
    logic [DATA_W-1:0]  r_sub;
    logic [DATA_W-1:0]  r_dat;

    logic [DATA_W-1:0]  w_sub;
    logic [DATA_W-1:0]  w_dat;
    logic               w_end;
    logic               w_dly;
    logic               w_last;
    logic               w_unused;

    assign w_sub  = tbl_data_i[2*DATA_W-1:DATA_W];
    assign w_dat  = tbl_data_i[DATA_W-1:0];
    assign w_end  = (w_sub == '1) && (w_dat == '1);
    assign w_dly  = (w_sub == {{(DATA_W-1){1'b1}}, 1'b0});
    assign w_last = (r_ptr == LAST);

    // Sub-address/data ready always arrive with ctrl_rdy_i.
    assign w_unused = ^{tx_sub_adr_rdy_i, tx_data_rdy_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_vld      <= 1'b0;
            r_wb_first <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_dly      <= '0;
            r_sub      <= '0;
            r_dat      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_dly) begin
                        if (w_dat != '0) begin
                            r_dly   <= DLY_W'(w_dat);
                            r_state <= S_DELAY;
                        end else if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_ptr + AW'(1);
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_sub   <= w_sub;
                        r_dat   <= w_dat;
                        r_vld   <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ctrl_rdy_i) begin
                        r_vld      <= 1'b0;
                        r_cnt      <= r_cnt + CW'(1);
                        r_wb_first <= 1'b1;
                        r_state    <= S_WAIT_BUS;
                    end
                end
                S_WAIT_BUS: begin
                    // Controller raises its busy one cycle late; skip that cycle.
                    if (r_wb_first) begin
                        r_wb_first <= 1'b0;
                    end else if (!sccb_busy_i) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_ptr + AW'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_tick_i) begin
                        r_dly <= r_dly - DLY_W'(1);
                        if (r_dly == DLY_W'(1)) begin
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_ptr   <= r_ptr + AW'(1);
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign entry_cnt_o      = r_cnt;
    assign tbl_addr_o       = r_ptr;
    assign trans_type_o     = 1'b1;
    assign phase_amt_o      = 2'd3;
    assign ctrl_vld_o       = r_vld;
    assign tx_sub_adr_vld_o = r_vld;
    assign tx_data_vld_o    = r_vld;
    assign tx_sub_adr_o     = r_sub;
    assign tx_data_o        = r_dat;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: table ROM, SCCB responder, tick source,
// and a table-walk reference model checked per scenario.
module tb_sccb_init_seq;

    localparam int AW = 6;
    localparam int N  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, done_o;
    logic [AW:0] entry_cnt_o;
    logic [AW-1:0] tbl_addr_o;
    logic [15:0] tbl_data_i = '0;
    logic        dly_tick_i = 1'b0;
    logic        trans_type_o;
    logic [1:0]  phase_amt_o;
    logic        ctrl_vld_o;
    logic        ctrl_rdy_i = 1'b0;
    logic [7:0]  tx_sub_adr_o;
    logic        tx_sub_adr_vld_o;
    logic        tx_sub_adr_rdy_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_data_vld_o;
    logic        tx_data_rdy_i = 1'b0;
    logic        sccb_busy_i = 1'b0;

    sccb_init_seq dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .entry_cnt_o      (entry_cnt_o),
        .tbl_addr_o       (tbl_addr_o),
        .tbl_data_i       (tbl_data_i),
        .dly_tick_i       (dly_tick_i),
        .trans_type_o     (trans_type_o),
        .phase_amt_o      (phase_amt_o),
        .ctrl_vld_o       (ctrl_vld_o),
        .ctrl_rdy_i       (ctrl_rdy_i),
        .tx_sub_adr_o     (tx_sub_adr_o),
        .tx_sub_adr_vld_o (tx_sub_adr_vld_o),
        .tx_sub_adr_rdy_i (tx_sub_adr_rdy_i),
        .tx_data_o        (tx_data_o),
        .tx_data_vld_o    (tx_data_vld_o),
        .tx_data_rdy_i    (tx_data_rdy_i),
        .sccb_busy_i      (sccb_busy_i)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [N];
    logic [15:0] hs_q [$];
    logic [15:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rdy_dly = 0;
    int bus_len = 0;
    int busy_cnt = 0;
    int tick_per = 0;
    int tick_ctr = 0;
    int ticks = 0;
    int vld_age = 0;
    int hs_pend = 0;
    int hs_cyc = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int addr1_cyc = -1;
    int vld_rises = 0;
    int first_rise_ticks = -1;
    int wrapped = 0;
    logic prev_busy = 1'b0;
    logic prev_vld = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    // Synchronous table ROM: data follows the address by one cycle.
    always @(posedge clk) tbl_data_i <= rom[tbl_addr_o];

    // Responder + monitor, on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (hs_pend != 0) begin
            hs_pend = 0;
            busy_cnt = bus_len;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tbl_addr_o === 6'd1 && addr1_cyc < 0) addr1_cyc = cyc;
        if (busy_o === 1'b1 && prev_busy && tbl_addr_o === 6'd0 && prev_addr != 6'd0)
            wrapped = 1;
        if (ctrl_vld_o === 1'b1 && !prev_vld) begin
            vld_rises++;
            if (first_rise_ticks < 0) first_rise_ticks = ticks;
        end
        prev_busy = (busy_o === 1'b1);
        prev_vld  = (ctrl_vld_o === 1'b1);
        prev_addr = tbl_addr_o;
        vld_age = (ctrl_vld_o === 1'b1) ? vld_age + 1 : 0;
        ctrl_rdy_i = (vld_age > rdy_dly) && !rst;
        tx_sub_adr_rdy_i = ctrl_rdy_i;
        tx_data_rdy_i = ctrl_rdy_i;
        if (ctrl_rdy_i) begin
            hs_q.push_back({tx_sub_adr_o, tx_data_o});
            hs_cyc = cyc;
            hs_pend = 1;
        end
        sccb_busy_i = (busy_cnt != 0);
        if (busy_cnt != 0) busy_cnt--;
        dly_tick_i = 1'b0;
        if (tick_per != 0) begin
            tick_ctr++;
            if (tick_ctr >= tick_per) begin
                tick_ctr = 0;
                dly_tick_i = 1'b1;
                ticks++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hs_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        addr1_cyc = -1;
        hs_cyc = -1;
        vld_rises = 0;
        first_rise_ticks = -1;
        wrapped = 0;
        ticks = 0;
        tick_ctr = 0;
    endtask

    task automatic fill_end();
        for (int i = 0; i < N; i++) rom[i] = 16'hFFFF;
    endtask

    // Reference: table walk from 0, skipping delays, stopping at end or depth.
    task automatic model();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i][15:8] != 8'hFE) exp_q.push_back(rom[i]);
        end
    endtask

    task automatic start_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cnt == 0 && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout done_cnt=%0d want>=1", nm, done_cnt);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy_o, done_o, ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 00000",
                {busy_o, done_o, ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o});
        end
        checks++;
        if (tbl_addr_o !== 6'd0 || entry_cnt_o !== 7'd0) begin
            errors++;
            $display("FAIL rst_addr_cnt got %0h/%0h want 0/0", tbl_addr_o, entry_cnt_o);
        end
        checks++;
        if (tx_sub_adr_o !== 8'h00 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL rst_payload got %0h/%0h want 0/0", tx_sub_adr_o, tx_data_o);
        end
        checks++;
        if (trans_type_o !== 1'b1 || phase_amt_o !== 2'd3) begin
            errors++;
            $display("FAIL const_out got %0b/%0d want 1/3", trans_type_o, phase_amt_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        fill_end();
        rom[0] = 16'h1280;
        rdy_dly = 0;
        bus_len = 20;
        clear_mon();
        start_run();
        wait_done("single");
        checks++;
        if (hs_q.size() != 1 || (hs_q.size() > 0 && hs_q[0] !== 16'h1280)) begin
            errors++;
            $display("FAIL single_hs got n=%0d first=%0h want n=1 1280",
                hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 16'h0);
        end
        // bus busy for bus_len cycles, one cycle to see release, then fetch
        checks++;
        if (addr1_cyc != hs_cyc + bus_len + 2) begin
            errors++;
            $display("FAIL single_bus_wait got %0d want %0d", addr1_cyc - hs_cyc, bus_len + 2);
        end
        // fetch addr 1, table data valid next cycle, done the cycle after
        checks++;
        if (done_cyc != addr1_cyc + 2) begin
            errors++;
            $display("FAIL single_done_lat got %0d want 2", done_cyc - addr1_cyc);
        end
        checks++;
        if (entry_cnt_o !== 7'd1 || busy_o !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_end got cnt=%0d busy=%b dones=%0d want 1/0/1",
                entry_cnt_o, busy_o, done_cnt);
        end
    endtask

    task automatic test_latency();
        fill_end();
        rom[0] = 16'h3377;
        rdy_dly = 2;
        bus_len = 1;
        clear_mon();
        start_run();
        checks++;
        if (tbl_addr_o !== 6'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL lat_n1 got addr=%0d busy=%b want 0/1", tbl_addr_o, busy_o);
        end
        step();
        checks++;
        if (ctrl_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL lat_n2 got vld=%b want 0", ctrl_vld_o);
        end
        step();
        checks++;
        if (ctrl_vld_o !== 1'b1 || {tx_sub_adr_o, tx_data_o} !== 16'h3377) begin
            errors++;
            $display("FAIL lat_n3 got vld=%b pl=%0h want 1 3377",
                ctrl_vld_o, {tx_sub_adr_o, tx_data_o});
        end
        wait_done("latency");
    endtask

    task automatic test_delay();
        fill_end();
        rom[0] = 16'hFE03;
        rom[1] = 16'h1100;
        rdy_dly = 0;
        bus_len = 3;
        clear_mon();
        tick_per = 10;
        start_run();
        wait_done("delay");
        tick_per = 0;
        checks++;
        if (first_rise_ticks != 3) begin
            errors++;
            $display("FAIL delay_ticks got %0d want 3", first_rise_ticks);
        end
        checks++;
        if (entry_cnt_o !== 7'd1 || hs_q.size() != 1 ||
            (hs_q.size() > 0 && hs_q[0] !== 16'h1100)) begin
            errors++;
            $display("FAIL delay_hs got cnt=%0d n=%0d want 1/1", entry_cnt_o, hs_q.size());
        end
    endtask

    task automatic test_hold();
        logic [15:0] pl;
        int n = 0;
        fill_end();
        rom[0] = 16'h5A3C;
        rdy_dly = 50;
        bus_len = 2;
        clear_mon();
        start_run();
        while (ctrl_vld_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        pl = {tx_sub_adr_o, tx_data_o};
        checks++;
        if (pl !== 16'h5A3C) begin
            errors++;
            $display("FAIL hold_payload got %0h want 5a3c", pl);
        end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if ({ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o} !== 3'b111 ||
                {tx_sub_adr_o, tx_data_o} !== pl) begin
                errors++;
                $display("FAIL hold_c%0d got vld=%b pl=%0h want 111 %0h", i,
                    {ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o},
                    {tx_sub_adr_o, tx_data_o}, pl);
            end
            step();
        end
        step();
        checks++;
        if ({ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o} !== 3'b000) begin
            errors++;
            $display("FAIL hold_drop got %b want 000",
                {ctrl_vld_o, tx_sub_adr_vld_o, tx_data_vld_o});
        end
        wait_done("hold");
        rdy_dly = 0;
        checks++;
        if (hs_q.size() != 1 || vld_rises != 1) begin
            errors++;
            $display("FAIL hold_single got hs=%0d rises=%0d want 1/1", hs_q.size(), vld_rises);
        end
    endtask

    task automatic test_no_end();
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] s;
            s = 8'($urandom);
            if (s == 8'hFE) s = 8'h3E;
            rom[i] = {s, 8'($urandom)};
            if (rom[i] == 16'hFFFF) rom[i] = 16'hFF00;
        end
        rom[5] = 16'hFF00;
        model();
        rdy_dly = int'($urandom_range(0, 3));
        bus_len = int'($urandom_range(0, 3));
        clear_mon();
        start_run();
        wait_done("no_end");
        checks++;
        if (hs_q.size() != N || entry_cnt_o !== 7'd64) begin
            errors++;
            $display("FAIL noend_count got hs=%0d cnt=%0d want 64/64", hs_q.size(), entry_cnt_o);
        end
        for (int i = 0; i < N && i < hs_q.size(); i++)
            if (hs_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL noend_payload got %0d wrong entries want 0", bad);
        end
        checks++;
        if (wrapped != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL noend_wrap got wrap=%0d dones=%0d want 0/1", wrapped, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        fill_end();
        rom[0] = 16'h2211;
        rom[1] = 16'h4433;
        rdy_dly = 0;
        bus_len = 30;
        clear_mon();
        start_run();
        while (hs_q.size() == 0 && n < 50) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy_o !== 1'b0 || ctrl_vld_o !== 1'b0 || entry_cnt_o !== 7'd0 ||
            tbl_addr_o !== 6'd0) begin
            errors++;
            $display("FAIL rstmid got busy=%b vld=%b cnt=%0d addr=%0d want 0/0/0/0",
                busy_o, ctrl_vld_o, entry_cnt_o, tbl_addr_o);
        end
        rst = 1'b0;
        bus_len = 2;
        repeat (40) step();
        model();
        clear_mon();
        start_run();
        checks++;
        if (tbl_addr_o !== 6'd0 || entry_cnt_o !== 7'd0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart got addr=%0d cnt=%0d busy=%b want 0/0/1",
                tbl_addr_o, entry_cnt_o, busy_o);
        end
        wait_done("rstmid");
        checks++;
        if (entry_cnt_o !== 7'(exp_q.size()) || hs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_cnt got %0d/%0d want %0d", entry_cnt_o, hs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_start_busy();
        fill_end();
        rom[0] = 16'h0A0B;
        rom[1] = 16'h0C0D;
        rdy_dly = 1;
        bus_len = 5;
        clear_mon();
        start_run();
        for (int k = 0; k < 3; k++) begin
            repeat (3) step();
            start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        wait_done("start_busy");
        repeat (20) step();
        checks++;
        if (done_cnt != 1 || hs_q.size() != 2 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_busy got dones=%0d hs=%0d busy=%b want 1/2/0",
                done_cnt, hs_q.size(), busy_o);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int len;
            int bad;
            fill_end();
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                logic [7:0] s;
                logic [7:0] d;
                if ($urandom_range(0, 9) < 2) begin
                    rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
                end else begin
                    s = 8'($urandom);
                    d = 8'($urandom);
                    if (s == 8'hFE) s = 8'h5E;
                    if (s == 8'hFF && d == 8'hFF) d = 8'h00;
                    rom[i] = {s, d};
                end
            end
            if (r == 0) rom[0] = 16'hFE00;
            model();
            rdy_dly = int'($urandom_range(0, 4));
            bus_len = int'($urandom_range(0, 6));
            clear_mon();
            tick_per = int'($urandom_range(2, 6));
            start_run();
            wait_done("random");
            tick_per = 0;
            bad = 0;
            for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
                if (hs_q[i] !== exp_q[i]) bad++;
            checks++;
            if (hs_q.size() != exp_q.size() || bad != 0) begin
                errors++;
                $display("FAIL rand%0d_hs got n=%0d bad=%0d want n=%0d bad=0",
                    r, hs_q.size(), bad, exp_q.size());
            end
            checks++;
            if (entry_cnt_o !== 7'(exp_q.size()) || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_cnt got %0d dones=%0d want %0d/1",
                    r, entry_cnt_o, done_cnt, exp_q.size());
            end
        end
    endtask

    initial begin
        fill_end();
        test_reset();
        test_single();
        test_latency();
        test_delay();
        test_hold();
        test_no_end();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
